// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding, ALU opcodes,
// requester IDs and a grant one-hot helper.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_structural.sv
// Combinational ALU: shared adder for ADD/SUB (carry_in acts as borrow on SUB),
// bitwise ops, logical shifts; zero flag on every op, signed overflow on ADD/SUB only.
module alu_structural
  import alu_arb_pkg::*;
#(
  parameter int OPERATION = 3,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 3
) (
  input  logic [OPERATION-1:0] op,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [SHIFT-1:0]     shamt,
  input  logic                 carry_in,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow
);

  logic             sub_s;
  logic [WIDTH-1:0] b_s;
  logic             cin_s;
  logic [WIDTH-1:0] sum_s;
  logic             add_ovf_s;

  // x - y - borrow is computed as x + ~y + ~borrow on the same adder
  assign sub_s     = (op == OP_SUB);
  assign b_s       = sub_s ? ~y : y;
  assign cin_s     = sub_s ? ~carry_in : carry_in;
  assign sum_s     = x + b_s + {{(WIDTH-1){1'b0}}, cin_s};
  assign add_ovf_s = (x[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != x[WIDTH-1]);

  // Opcode decode
  always_comb begin
    result   = {WIDTH{1'b0}};
    overflow = 1'b0;
    case (op)
      OP_ADD:  begin result = sum_s; overflow = add_ovf_s; end
      OP_SUB:  begin result = sum_s; overflow = add_ovf_s; end
      OP_AND:  result = x & y;
      OP_OR:   result = x | y;
      OP_XOR:  result = x ^ y;
      OP_SHL:  result = x << shamt;
      OP_SHR:  result = x >> shamt;
      OP_PASS: result = x;
      default: result = {WIDTH{1'b0}};
    endcase
  end

  assign zero = (result == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one alu_structural between two valid/ready requesters,
// one transaction in flight. Optional per-requester grant counters: ALU_ARB_STATS_EN.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int OPERATION = 3,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*OPERATION-1:0] req_op,
  input  logic [2*WIDTH-1:0]     req_x,
  input  logic [2*WIDTH-1:0]     req_y,
  input  logic [2*SHIFT-1:0]     req_shamt,
  input  logic [1:0]             req_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_overflow,
  output logic [2*CNT_W-1:0]     grant_cnt
);

  arb_state_t state_r, state_nxt_s;

  logic                 last_id_r;
  logic                 grant_vld_s;
  logic                 grant_id_s;
  logic [1:0]           req_ready_s;
  logic                 accept_s;

  logic [OPERATION-1:0] op_r;
  logic [WIDTH-1:0]     x_r, y_r;
  logic [SHIFT-1:0]     shamt_r;
  logic                 carry_r;
  logic                 id_r;

  logic                 rsp_valid_r, rsp_id_r, rsp_zero_r, rsp_overflow_r;
  logic [WIDTH-1:0]     rsp_result_r;

  logic [WIDTH-1:0]     alu_result_s;
  logic                 alu_zero_s, alu_overflow_s;

  // Round-robin pick: a tie goes to the requester not served last
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = REQ_ID_0;
    case (req_valid)
      2'b01:   begin grant_vld_s = 1'b1; grant_id_s = REQ_ID_0;   end
      2'b10:   begin grant_vld_s = 1'b1; grant_id_s = REQ_ID_1;   end
      2'b11:   begin grant_vld_s = 1'b1; grant_id_s = ~last_id_r; end
      default: begin grant_vld_s = 1'b0; grant_id_s = REQ_ID_0;   end
    endcase
  end

  // Next-state and accept; reset blocks any accept in the cycle it is asserted
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s && !rst) begin
          req_ready_s = id_onehot(grant_id_s);
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign accept_s = |req_ready_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand latch on accept, response capture in EXEC, release on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_r      <= REQ_ID_1;
      op_r           <= {OPERATION{1'b0}};
      x_r            <= {WIDTH{1'b0}};
      y_r            <= {WIDTH{1'b0}};
      shamt_r        <= {SHIFT{1'b0}};
      carry_r        <= 1'b0;
      id_r           <= REQ_ID_0;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= 1'b0;
      rsp_result_r   <= {WIDTH{1'b0}};
      rsp_zero_r     <= 1'b0;
      rsp_overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r      <= grant_id_s ? req_op[2*OPERATION-1:OPERATION] : req_op[OPERATION-1:0];
        x_r       <= grant_id_s ? req_x[2*WIDTH-1:WIDTH]          : req_x[WIDTH-1:0];
        y_r       <= grant_id_s ? req_y[2*WIDTH-1:WIDTH]          : req_y[WIDTH-1:0];
        shamt_r   <= grant_id_s ? req_shamt[2*SHIFT-1:SHIFT]      : req_shamt[SHIFT-1:0];
        carry_r   <= grant_id_s ? req_carry[1]                    : req_carry[0];
        id_r      <= grant_id_s;
        last_id_r <= grant_id_s;
      end
      if (state_r == ST_EXEC) begin
        rsp_valid_r    <= 1'b1;
        rsp_id_r       <= id_r;
        rsp_result_r   <= alu_result_s;
        rsp_zero_r     <= alu_zero_s;
        rsp_overflow_r <= alu_overflow_s;
      end else if (state_r == ST_RESP && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  alu_structural #(
    .OPERATION(OPERATION),
    .WIDTH    (WIDTH),
    .SHIFT    (SHIFT)
  ) u_alu (
    .op      (op_r),
    .x       (x_r),
    .y       (y_r),
    .shamt   (shamt_r),
    .carry_in(carry_r),
    .result  (alu_result_s),
    .zero    (alu_zero_s),
    .overflow(alu_overflow_s)
  );

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_r, cnt1_r;

  // Per-requester accept counters, wrapping naturally at 2**CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (grant_id_s) cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else            cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign grant_cnt = {cnt1_r, cnt0_r};
`else
  assign grant_cnt = {(2*CNT_W){1'b0}};
`endif

  assign req_ready    = req_ready_s;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_id       = rsp_id_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_zero     = rsp_zero_r;
  assign rsp_overflow = rsp_overflow_r;

endmodule
